// File: rtl/constants_pkg.sv
// Shared datapath definitions: the ALU/register-file operation codes
// understood by the datapath that instr_sequencer drives.
package constants_pkg;

  typedef enum logic [1:0] {
    REG_READ  = 2'd0,
    REG_WRITE = 2'd1,
    ADD       = 2'd2,
    SUB       = 2'd3
  } ALUOp;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch port: registered request/address from the
// sequencer, acknowledge with same-cycle instruction data from memory.
interface instr_sequencer_if #(
  parameter int DATA_BITS = 8
);
  logic                 req;
  logic [DATA_BITS-1:0] addr;
  logic                 ack;
  logic [15:0]          data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/issue control stage for the register-file/ALU datapath.
// Optional feature: define SEQ_JUMP_EN to enable the JMP (0x5) instruction.
module instr_sequencer
  import constants_pkg::*;
#(
  parameter int ADDR_BITS   = 3,
  parameter int DATA_BITS   = 8,
  parameter int EXEC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  instr_sequencer_if.master    imem,
  output ALUOp                 op,
  output logic [ADDR_BITS-1:0] addr_a,
  output logic [ADDR_BITS-1:0] addr_b,
  output logic [ADDR_BITS-1:0] addr_r,
  output logic [DATA_BITS-1:0] data_in,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 read_valid,
  output logic [DATA_BITS-1:0] pc,
  output logic                 halted,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] OPC_NOP   = 4'h0;
  localparam logic [3:0] OPC_LOADI = 4'h1;
  localparam logic [3:0] OPC_ADD   = 4'h2;
  localparam logic [3:0] OPC_SUB   = 4'h3;
  localparam logic [3:0] OPC_READ  = 4'h4;
  localparam logic [3:0] OPC_JMP   = 4'h5;
  localparam logic [3:0] OPC_HALT  = 4'hF;
  localparam logic [1:0] EXEC_LAST = 2'(EXEC_CYCLES - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] pc_q, pc_d;
  logic [15:0]          ir_q, ir_d;
  logic                 req_q, req_d;
  logic [1:0]           cnt_q, cnt_d;
  ALUOp                 op_q, op_d;
  logic [ADDR_BITS-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_r_q, addr_r_d;
  logic [DATA_BITS-1:0] data_in_q, data_in_d;
  logic [DATA_BITS-1:0] read_data_q, read_data_d;
  logic                 read_valid_q, read_valid_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;
  logic                 boundary_s;

  logic [3:0]           opcode_s;
  logic [ADDR_BITS-1:0] rd_s, ra_s, rb_s;
  logic [DATA_BITS-1:0] imm_s;

  assign opcode_s = ir_q[15:12];
  assign rd_s     = ADDR_BITS'(ir_q[11:9]);
  assign ra_s     = ADDR_BITS'(ir_q[8:6]);
  assign rb_s     = ADDR_BITS'(ir_q[5:3]);
  assign imm_s    = DATA_BITS'(ir_q[7:0]);

  // Next-state, fetch handshake and datapath drive; idle drive is the default.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    req_d        = 1'b0;
    cnt_d        = cnt_q;
    op_d         = REG_READ;
    addr_a_d     = '0;
    addr_b_d     = '0;
    addr_r_d     = '0;
    data_in_d    = '0;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    boundary_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (req_q && imem.ack) begin
          ir_d    = imem.data;
          state_d = S_DECODE;
        end else begin
          req_d = 1'b1;
        end
      end
      S_DECODE: begin
        pc_d  = pc_q + DATA_BITS'(1'b1);
        cnt_d = 2'd0;
        case (opcode_s)
          OPC_NOP: boundary_s = 1'b1;
          OPC_LOADI: begin
            state_d   = S_EXEC;
            op_d      = REG_WRITE;
            addr_a_d  = rd_s;
            data_in_d = imm_s;
          end
          OPC_ADD, OPC_SUB: begin
            state_d  = S_EXEC;
            op_d     = (opcode_s == OPC_ADD) ? ADD : SUB;
            addr_a_d = ra_s;
            addr_b_d = rb_s;
            addr_r_d = rd_s;
          end
          OPC_READ: begin
            state_d  = S_EXEC;
            op_d     = REG_READ;
            addr_a_d = ra_s;
          end
`ifdef SEQ_JUMP_EN
          OPC_JMP: begin
            pc_d       = imm_s;
            boundary_s = 1'b1;
          end
`endif
          OPC_HALT: begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end
          default: begin
            illegal_d  = 1'b1;
            boundary_s = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (cnt_q == EXEC_LAST) begin
          // Only READ issues REG_READ inside EXEC, so op_q identifies it here.
          boundary_s = 1'b1;
          if (op_q == REG_READ) begin
            read_data_d  = rd_data;
            read_valid_d = 1'b1;
          end else begin
            read_valid_d = 1'b0;
          end
        end else begin
          cnt_d     = cnt_q + 2'd1;
          op_d      = op_q;
          addr_a_d  = addr_a_q;
          addr_b_d  = addr_b_q;
          addr_r_d  = addr_r_q;
          data_in_d = data_in_q;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    // Instruction boundary: continue fetching or park in IDLE.
    state_d = boundary_s ? (run ? S_FETCH : S_IDLE) : state_d;
    req_d   = boundary_s ? run : req_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= 16'h0000;
      req_q        <= 1'b0;
      cnt_q        <= 2'd0;
      op_q         <= REG_READ;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      addr_r_q     <= '0;
      data_in_q    <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      addr_r_q     <= addr_r_d;
      data_in_q    <= data_in_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = pc_q;
  assign op         = op_q;
  assign addr_a     = addr_a_q;
  assign addr_b     = addr_b_q;
  assign addr_r     = addr_r_q;
  assign data_in    = data_in_q;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instruction memory with programmable
// ack delay, a small register-file/ALU stub, table-driven programs and corner cases.
module tb_instr_sequencer;
  import constants_pkg::*;

  localparam int EXEC_CYCLES = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  ALUOp       op;
  logic [2:0] addr_a, addr_b, addr_r;
  logic [7:0] data_in, rd_data, read_data, pc;
  logic       read_valid, halted, illegal;

  instr_sequencer_if #(.DATA_BITS(8)) ifc ();

  instr_sequencer #(.ADDR_BITS(3), .DATA_BITS(8), .EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk(clk), .reset(reset), .run(run), .imem(ifc),
    .op(op), .addr_a(addr_a), .addr_b(addr_b), .addr_r(addr_r),
    .data_in(data_in), .rd_data(rd_data), .read_data(read_data),
    .read_valid(read_valid), .pc(pc), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Instruction memory with a programmable number of wait cycles per fetch.
  logic [15:0] mem [256];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  assign ifc.ack  = ifc.req && (wait_cnt >= ack_delay);
  assign ifc.data = mem[ifc.addr];

  always @(posedge clk) begin
    if (ifc.req && !ifc.ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // Register-file / ALU stub standing in for the downstream datapath.
  logic [7:0] rf [8];
  assign rd_data = rf[addr_a];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else begin
      case (op)
        REG_WRITE: rf[addr_a] <= data_in;
        ADD:       rf[addr_r] <= rf[addr_a] + rf[addr_b];
        SUB:       rf[addr_r] <= rf[addr_a] - rf[addr_b];
        default:   ;
      endcase
    end
  end

  // Fetch-port monitor: an unacknowledged request must hold req and addr.
  int   req_drop_errs = 0;
  int   addr_errs = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  always @(posedge clk) begin
    if (reset && prev_req && !prev_ack) begin
      if (!ifc.req) req_drop_errs <= req_drop_errs + 1;
      else if (ifc.addr != prev_addr) addr_errs <= addr_errs + 1;
    end
    prev_req  <= ifc.req;
    prev_ack  <= ifc.ack;
    prev_addr <= ifc.addr;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input int opc, input int rd, input int ra, input int rb);
    return {opc[3:0], rd[2:0], ra[2:0], rb[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input int opc, input int rd, input int imm);
    return {opc[3:0], rd[2:0], 1'b0, imm[7:0]};
  endfunction

  typedef struct {
    logic [5:0][15:0] prog;
    int               delay;
    logic [7:0]       exp_rd;
    logic [7:0]       exp_pc;
    logic             exp_ill;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3, w4, w5,
                              input int d, input logic [7:0] erd, epc, input logic eill);
    vec_t v;
    v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2;
    v.prog[3] = w3; v.prog[4] = w4; v.prog[5] = w5;
    v.delay = d; v.exp_rd = erd; v.exp_pc = epc; v.exp_ill = eill;
    return v;
  endfunction

  task automatic load(input logic [5:0][15:0] p);
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    for (int i = 0; i < 6; i++) mem[i] = p[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  localparam logic [15:0] HLT = 16'hF000;

  vec_t vecs [6];
  int   reads, seen, n, reqs;

  initial begin
    vecs[0] = mk(enc_i(1, 1, 8'h05), enc_i(1, 2, 8'h03), enc_r(2, 3, 1, 2), enc_r(4, 0, 3, 0),
                 HLT, HLT, 0, 8'h08, 8'd5, 1'b0);
    vecs[1] = mk(enc_i(1, 1, 8'h03), enc_i(1, 2, 8'h05), enc_r(3, 4, 1, 2), enc_r(4, 0, 4, 0),
                 HLT, HLT, 0, 8'hFE, 8'd5, 1'b0);
    vecs[2] = mk(enc_i(1, 1, 8'h05), enc_i(1, 2, 8'h03), enc_r(2, 3, 1, 2), enc_r(4, 0, 3, 0),
                 HLT, HLT, 3, 8'h08, 8'd5, 1'b0);
    vecs[3] = mk(16'h7000, enc_i(1, 5, 8'hA5), enc_r(4, 0, 5, 0), HLT,
                 HLT, HLT, 0, 8'hA5, 8'd4, 1'b1);
    vecs[4] = mk(16'h0000, enc_i(1, 7, 8'hFF), enc_i(1, 6, 8'h01), enc_r(2, 0, 7, 6),
                 enc_r(4, 0, 0, 0), HLT, 1, 8'h00, 8'd6, 1'b0);
    vecs[5] = mk(16'h153C, enc_r(4, 0, 2, 0), HLT, HLT,
                 HLT, HLT, 0, 8'h3C, 8'd3, 1'b0);

    for (int i = 0; i < 256; i++) mem[i] = HLT;
    do_reset();
    @(negedge clk);
    check("rst_req", 32'(ifc.req), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_op", 32'(op), 32'(REG_READ));
    check("rst_read_data", 32'(read_data), 32'd0);
    check("rst_read_valid", 32'(read_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      load(vecs[v].prog);
      ack_delay = vecs[v].delay;
      run = 1'b1;
      reads = 0;
      for (int c = 0; c < 400 && !halted; c++) begin
        @(negedge clk);
        if (read_valid) reads++;
      end
      check($sformatf("v%0d_halted", v), 32'(halted), 32'd1);
      check($sformatf("v%0d_read_data", v), 32'(read_data), 32'(vecs[v].exp_rd));
      check($sformatf("v%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
      check($sformatf("v%0d_illegal", v), 32'(illegal), 32'(vecs[v].exp_ill));
      check($sformatf("v%0d_valid_cycles", v), 32'(reads), 32'd1);
      check($sformatf("v%0d_req_hold", v), 32'(req_drop_errs), 32'd0);
      check($sformatf("v%0d_addr_hold", v), 32'(addr_errs), 32'd0);
      run = 1'b0;
    end

    // Reset in the middle of a waiting fetch, after illegal and pc have moved.
    do_reset();
    load({HLT, HLT, HLT, HLT, HLT, 16'h7000});
    ack_delay = 2;
    run = 1'b1;
    for (int c = 0; c < 50 && !illegal; c++) @(negedge clk);
    check("mid_fetch_pre_req", 32'(ifc.req), 32'd1);
    check("mid_fetch_pre_pc", 32'(pc), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_fetch_req", 32'(ifc.req), 32'd0);
    check("mid_fetch_pc", 32'(pc), 32'd0);
    check("mid_fetch_halted", 32'(halted), 32'd0);
    check("mid_fetch_illegal", 32'(illegal), 32'd0);

    // Drop run during the ADD: it completes, then the block parks in IDLE.
    do_reset();
    load(vecs[0].prog);
    run = 1'b1;
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      @(negedge clk);
      if (op == ADD) seen = 1;
    end
    check("add_seen", 32'(seen), 32'd1);
    check("add_addr_a", 32'(addr_a), 32'd1);
    check("add_addr_b", 32'(addr_b), 32'd2);
    check("add_addr_r", 32'(addr_r), 32'd3);
    run = 1'b0;
    n = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (op == ADD) n++;
      else break;
    end
    check("add_hold_cycles", 32'(n), 32'(EXEC_CYCLES));
    reqs = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.req) reqs++;
    end
    check("stop_no_req", 32'(reqs), 32'd0);
    check("stop_pc", 32'(pc), 32'd3);
    check("stop_add_result", 32'(rf[3]), 32'h08);
    check("stop_halted", 32'(halted), 32'd0);

    // JMP 0xFF followed by a NOP at 0xFF.
    do_reset();
    load({HLT, HLT, HLT, HLT, HLT, 16'h50FF});
    mem[255] = 16'h0000;
    run = 1'b1;
`ifdef SEQ_JUMP_EN
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge clk);
      if (ifc.req && ifc.addr == 8'hFF) seen = 1;
    end
    check("jmp_fetch_ff", 32'(seen), 32'd1);
    run = 1'b0;
    repeat (5) @(negedge clk);
    check("jmp_wrap_pc", 32'(pc), 32'h00);
    check("jmp_illegal", 32'(illegal), 32'd0);
`else
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge clk);
      if (ifc.req) seen = 1;
    end
    check("jmp_fetch_0", 32'(seen), 32'd1);
    run = 1'b0;
    repeat (5) @(negedge clk);
    check("nojmp_pc", 32'(pc), 32'h01);
    check("nojmp_illegal", 32'(illegal), 32'd1);
`endif
    check("jmp_idle_req", 32'(ifc.req), 32'd0);

    // Reset during EXEC of a LOADI returns the datapath to idle drive at once.
    do_reset();
    load(vecs[0].prog);
    run = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge clk);
      if (op == REG_WRITE) seen = 1;
    end
    check("exec_pre_data_in", 32'(data_in), 32'h05);
    #2 reset = 1'b0;
    #1;
    check("exec_rst_op", 32'(op), 32'(REG_READ));
    check("exec_rst_addr_a", 32'(addr_a), 32'd0);
    check("exec_rst_data_in", 32'(data_in), 32'd0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
